// File: rtl/uart_rx_oversample_pkg.sv
// Shared definitions for the oversampling UART receiver and its companion
// transmitter: FSM states, oversample constants and the baud divider math.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OS_RATE = 16;

    localparam logic [3:0] SMP_A   = 4'd7;
    localparam logic [3:0] SMP_B   = 4'd8;
    localparam logic [3:0] SMP_C   = 4'd9;
    localparam logic [3:0] BIT_END = 4'd15;

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (baud * OS_RATE) / 2) / (baud * OS_RATE);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receiver-side bundle: the raw serial pin plus the byte/error event outputs.
interface uart_rx_oversample_if;

    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks while enabled,
// counter parked at zero while disabled so each frame starts phase-aligned.
// DIV must be at least 2.
module uart_os_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Free-running 0..DIV-1 divider, cleared whenever the receiver is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling 8N1 receiver: input synchronizer, 3-point majority vote,
// false-start rejection, stop-bit check, one-cycle byte and error strobes.
module uart_rx_oversample
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_oversample_if.master bus
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    rx_state_t  state;
    rx_state_t  next_state;

    logic       sync1;
    logic       rx_s;
    logic       rx_d;
    logic       tick;
    logic [3:0] s_cnt;
    logic [2:0] bit_idx;
    logic       samp_a;
    logic       samp_b;
    logic       maj;
    logic [7:0] shift_reg;
    logic [7:0] data_out_r;
    logic       data_valid_r;
    logic       frame_err_r;

    logic       at_a;
    logic       at_b;
    logic       at_c;
    logic       at_end;
    logic       shift_en;
    logic       load_byte;
    logic       set_err;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != IDLE),
        .tick  (tick)
    );

    assign at_a   = tick && (s_cnt == SMP_A);
    assign at_b   = tick && (s_cnt == SMP_B);
    assign at_c   = tick && (s_cnt == SMP_C);
    assign at_end = tick && (s_cnt == BIT_END);
    assign maj    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    // Two-flop synchronizer plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control decisions, all keyed off the sample ticks.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    next_state = START;
                end
            end
            START: begin
                if (at_c && maj) begin
                    next_state = IDLE;
                end else if (at_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                shift_en = at_c;
                if (at_end && (bit_idx == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (at_c) begin
                    load_byte  = maj;
                    set_err    = !maj;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Sample counters, vote samples, shift register and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cnt        <= 4'd0;
            bit_idx      <= 3'd0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shift_reg    <= 8'd0;
            data_out_r   <= 8'd0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            data_valid_r <= load_byte;
            frame_err_r  <= set_err;
            if (load_byte) begin
                data_out_r <= shift_reg;
            end
            if (state == IDLE) begin
                s_cnt   <= 4'd0;
                bit_idx <= 3'd0;
            end else if (tick) begin
                s_cnt <= s_cnt + 4'd1;
                if ((state == DATA) && at_end) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
            if (at_a) begin
                samp_a <= rx_s;
            end
            if (at_b) begin
                samp_b <= rx_s;
            end
            if (shift_en) begin
                shift_reg <= {maj, shift_reg[7:1]};
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed plus randomized bench for uart_rx_oversample with a frame-level
// reference model: each sent frame predicts one byte event, one framing
// error event, or nothing.
module tb_uart_rx_oversample;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
        logic       busy;
        int         cyc;
    } event_t;

    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         start_cyc = 0;
    logic [7:0] last_good = 8'd0;
    event_t     obs[$];
    event_t     exp_q[$];
    event_t     mon_ev;

    uart_rx_oversample_if bus_if ();

    uart_rx_oversample #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Cycle counter for timing checks.
    always @(posedge clk) cyc++;

    // Monitor: record every strobe observed on the falling edge.
    always @(negedge clk) begin
        if (bus_if.data_valid === 1'b1) begin
            mon_ev.is_err = 1'b0;
            mon_ev.val    = bus_if.data_out;
            mon_ev.busy   = bus_if.busy;
            mon_ev.cyc    = cyc;
            obs.push_back(mon_ev);
        end
        if (bus_if.frame_err === 1'b1) begin
            mon_ev.is_err = 1'b1;
            mon_ev.val    = bus_if.data_out;
            mon_ev.busy   = bus_if.busy;
            mon_ev.cyc    = cyc;
            obs.push_back(mon_ev);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveLevel(input logic lvl, input int n);
        bus_if.rx = lvl;
        idle(n);
    endtask

    // One 8N1 frame; glitch_bit >= 0 inverts that bit for 15 clks over its middle sample.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int glitch_bit);
        start_cyc = cyc;
        driveLevel(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                driveLevel(b[i], 81);
                driveLevel(!b[i], 15);
                driveLevel(b[i], BIT_CLKS - 96);
            end else begin
                driveLevel(b[i], BIT_CLKS);
            end
        end
        driveLevel(stop_ok, BIT_CLKS);
    endtask

    // Reference model: a good stop bit yields the byte, a bad one yields an
    // error event with data_out still showing the last good byte.
    task automatic expectFrame(input logic [7:0] b, input bit stop_ok);
        event_t e;
        e.is_err = !stop_ok;
        e.val    = stop_ok ? b : last_good;
        e.busy   = 1'b0;
        e.cyc    = 0;
        exp_q.push_back(e);
        if (stop_ok) last_good = b;
    endtask

    task automatic compareEvents(input string tag);
        checkOutput({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs.size()) begin
                checkOutput({tag, "_kind"}, 32'(obs[i].is_err), 32'(exp_q[i].is_err));
                checkOutput({tag, "_data"}, 32'(obs[i].val), 32'(exp_q[i].val));
                checkOutput({tag, "_busy"}, 32'(obs[i].busy), 32'd0);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        bit         rok;
        int         lat;

        reset     = 1'b0;
        bus_if.rx = 1'b1;
        idle(5);
        checkOutput("rst_data_out", 32'(bus_if.data_out), 32'd0);
        checkOutput("rst_data_valid", 32'(bus_if.data_valid), 32'd0);
        checkOutput("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
        checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
        reset = 1'b1;
        idle(20);

        $display("[TB] clean byte 0xA5");
        fork
            applyStimulus(8'hA5, 1'b1, -1);
            begin
                idle(100);
                checkOutput("busy_mid_frame", 32'(bus_if.busy), 32'd1);
            end
        join
        expectFrame(8'hA5, 1'b1);
        idle(40);
        if (obs.size() > 0) begin
            lat = obs[0].cyc - start_cyc;
            checkOutput("latency_window", 32'(lat >= 1523 && lat <= 1553), 32'd1);
        end
        compareEvents("clean");
        checkOutput("clean_hold", 32'(bus_if.data_out), 32'h0A5);

        $display("[TB] back-to-back 0x31 0x0D");
        applyStimulus(8'h31, 1'b1, -1);
        expectFrame(8'h31, 1'b1);
        applyStimulus(8'h0D, 1'b1, -1);
        expectFrame(8'h0D, 1'b1);
        idle(40);
        if (obs.size() == 2) begin
            checkOutput("b2b_spacing", 32'(obs[1].cyc - obs[0].cyc), 32'(10 * BIT_CLKS));
        end
        compareEvents("b2b");

        $display("[TB] false start");
        driveLevel(1'b0, 40);
        driveLevel(1'b1, 300);
        checkOutput("false_start_busy", 32'(bus_if.busy), 32'd0);
        compareEvents("false_start");
        applyStimulus(8'h55, 1'b1, -1);
        expectFrame(8'h55, 1'b1);
        idle(40);
        compareEvents("after_false_start");

        $display("[TB] framing error with stuck-low line");
        applyStimulus(8'h3C, 1'b0, -1);
        expectFrame(8'h3C, 1'b0);
        driveLevel(1'b0, 5 * BIT_CLKS);
        driveLevel(1'b1, 2 * BIT_CLKS);
        checkOutput("ferr_hold", 32'(bus_if.data_out), 32'h055);
        compareEvents("ferr");
        applyStimulus(8'h7E, 1'b1, -1);
        expectFrame(8'h7E, 1'b1);
        idle(40);
        compareEvents("after_ferr");

        $display("[TB] glitch on bit 3 of 0xF0");
        applyStimulus(8'hF0, 1'b1, 3);
        expectFrame(8'hF0, 1'b1);
        idle(40);
        compareEvents("glitch");

        $display("[TB] reset during data bit 4 of 0x99");
        driveLevel(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rb = 8'h99;
            driveLevel(rb[i], BIT_CLKS);
        end
        driveLevel(1'b1, 80);
        reset = 1'b0;
        idle(5);
        checkOutput("midrst_data_out", 32'(bus_if.data_out), 32'd0);
        checkOutput("midrst_data_valid", 32'(bus_if.data_valid), 32'd0);
        checkOutput("midrst_frame_err", 32'(bus_if.frame_err), 32'd0);
        checkOutput("midrst_busy", 32'(bus_if.busy), 32'd0);
        reset     = 1'b1;
        last_good = 8'd0;
        idle(2 * BIT_CLKS);
        compareEvents("midrst_abort");
        applyStimulus(8'h42, 1'b1, -1);
        expectFrame(8'h42, 1'b1);
        idle(40);
        compareEvents("after_midrst");

        $display("[TB] randomized frames");
        for (int n = 0; n < 10; n++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 3) != 0);
            applyStimulus(rb, rok, -1);
            expectFrame(rb, rok);
            if (rok) driveLevel(1'b1, $urandom_range(0, 100));
            else     driveLevel(1'b1, $urandom_range(20, 100));
        end
        idle(40);
        compareEvents("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
